h264_mb_scheduler: RTL and testbench
====================================

Name: h264_mb_scheduler

Overview:
Frame-level sequencer for the intra H.264 encoder top level. It walks the frame in macroblock raster order and streams each macroblock's pixel-word addresses to the intra4x4 (luma) and intra8x8cc (chroma) inputs, honouring their READYI/STROBEI handshakes. It pulses the slice and line markers and waits for xbuffer_DONE before moving to the next macroblock. The frame store sits outside the block and returns data combinationally from the addresses this block drives.

Parameters:
IMGWIDTH, 352, luma width in pixels; multiple of 16
IMGHEIGHT, 288, luma height in pixels; multiple of 16
IWBITS, 9, width of x and cx
IHBITS, 9, width of y and cy

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin one frame; sampled in IDLE only
newslice  out  1  one-cycle pulse at the first macroblock of the frame
newline  out  1  one-cycle pulse at the start of each macroblock row with mby>0
intra4x4_readyi  in  1  luma sink can accept a word
intra4x4_strobei  out  1  luma word transfer this cycle
x  out  IWBITS  luma pixel column of the current word
y  out  IHBITS  luma row of the current word
intra8x8cc_readyi  in  1  chroma sink can accept a word
intra8x8cc_strobei  out  1  chroma word transfer this cycle
cx  out  IWBITS  chroma pixel column
cy  out  IHBITS  chroma row
cuv  out  1  0 = U, 1 = V
xbuffer_done  in  1  macroblock fully consumed downstream
busy  out  1  high from the start accept until the frame ends
frame_done  out  1  one-cycle pulse after the last macroblock

Behaviour:
- Reset: state IDLE. All outputs 0, all counters 0, sticky done flag cleared. A reset mid-frame abandons the frame immediately.
- States and transitions:
  - IDLE: start=1 -> SLICE, busy=1.
  - SLICE: newslice=1 for one cycle -> LUMA.
  - LINE: newline=1 for one cycle -> LUMA.
  - LUMA -> CHROMA after 64 words.
  - CHROMA -> WAITX after 32 words.
  - WAITX: leave when xbuffer_done or the sticky flag is set; clear the flag. Last macroblock -> DONE. Otherwise -> NEXT.
  - NEXT: advance mbx; at wrap, mbx=0 and mby+1. If the new mbx==0 -> LINE, else -> LUMA.
  - DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- Luma stream:
  - intra4x4_strobei = (state==LUMA) & intra4x4_readyi, combinational.
  - x = mbx*16 + w*4, y = mby*16 + r, with w 0..3 and r 0..15, raster order w fastest.
  - Address valid in the strobe cycle; counters advance on the strobing edge.
  - readyi low holds the address unchanged.
- Chroma stream:
  - intra8x8cc_strobei = (state==CHROMA) & intra8x8cc_readyi.
  - cx = mbx*8 + w*4 (w 0..1), cy = mby*8 + r (r 0..7).
  - First 16 words cuv=0 (U), next 16 words cuv=1 (V).
- xbuffer_done seen in LUMA or CHROMA sets the sticky flag, so an early done is not lost.
- start while busy is ignored. start held high re-triggers from IDLE after frame_done.
- Address arithmetic is unsigned and truncated to the port widths. Counters are sized by $clog2 of IMGWIDTH/16 and IMGHEIGHT/16.
- Single-macroblock frame (16x16): newslice only, never newline, then frame_done.

Optional Feature:
H264_PARALLEL_CHROMA_EN:
- Defined: LUMA and CHROMA merge into one STREAM state. Both strobes may be active in the same cycle, each gated by its own readyi and its own remaining count. STREAM -> WAITX when both counts are exhausted. Minimum macroblock stream time is 64 cycles instead of 96.
- Undefined: sequential LUMA then CHROMA as described above.

Decomposition:
- Package h264_sched_pkg: state enum (IDLE, SLICE, LINE, LUMA, CHROMA, STREAM, WAITX, NEXT, DONE), LUMA_WORDS=64, CHROMA_WORDS=32, CHROMA_PER_PLANE=16.
- One sub-module, h264_mb_addr_gen: from mbx, mby and the word counters, produces x, y, cx, cy and cuv combinationally.

Test Plan:
- IMGWIDTH=32, IMGHEIGHT=32, readyi tied 1, xbuffer_done pulsed 3 cycles after CHROMA ends -> newslice once, newline once (at mb 2), 256 luma and 128 chroma strobes, frame_done once, busy low afterwards.
- Macroblock 1 (mbx=1, mby=0), luma word 5 -> x=20, y=1. Chroma word 17 -> cx=12, cy=0, cuv=1.
- intra4x4_readyi toggled 1,0,0,1 -> strobes only in ready cycles. x/y held while ready is low. Exactly 64 luma strobes per macroblock.
- xbuffer_done pulsed mid-LUMA -> WAITX exits in 1 cycle with no new done. A second done in WAITX is not double-counted.
- rst asserted at luma word 30 of macroblock 2 -> next cycle all outputs 0, state IDLE. A new start restarts at mb 0 with newslice.
- With H264_PARALLEL_CHROMA_EN, both readyi=1 -> 32 cycles of dual strobes, then 32 luma-only, then WAITX.

Source files
------------

// File: rtl/h264_sched_pkg.sv
// Shared types and constants for the H.264 intra macroblock scheduler.
package h264_sched_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SLICE,
        LINE,
        LUMA,
        CHROMA,
        STREAM,
        WAITX,
        NEXT,
        DONE
    } state_e;

    localparam int unsigned LUMA_WORDS       = 64;
    localparam int unsigned CHROMA_WORDS     = 32;
    localparam int unsigned CHROMA_PER_PLANE = 16;

    // Keeps macroblock counters at least one bit wide for single-macroblock dimensions.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/h264_mb_addr_gen.sv
// Combinational luma/chroma pixel-word address generator for the current macroblock.
module h264_mb_addr_gen
    import h264_sched_pkg::*;
#(
    parameter int unsigned MBXW   = 1,
    parameter int unsigned MBYW   = 1,
    parameter int unsigned IWBITS = 9,
    parameter int unsigned IHBITS = 9
) (
    input  logic [MBXW-1:0]   i_mbx,
    input  logic [MBYW-1:0]   i_mby,
    input  logic [5:0]        i_lcnt,
    input  logic [4:0]        i_ccnt,
    output logic [IWBITS-1:0] o_x,
    output logic [IHBITS-1:0] o_y,
    output logic [IWBITS-1:0] o_cx,
    output logic [IHBITS-1:0] o_cy,
    output logic              o_cuv
);

    // Luma word = {row[3:0], col[1:0]}; chroma word = {plane, row[2:0], col}.
    assign o_x   = IWBITS'({i_mbx, 4'b0000}) + IWBITS'({i_lcnt[1:0], 2'b00});
    assign o_y   = IHBITS'({i_mby, 4'b0000}) + IHBITS'(i_lcnt[5:2]);
    assign o_cx  = IWBITS'({i_mbx, 3'b000}) + IWBITS'({i_ccnt[0], 2'b00});
    assign o_cy  = IHBITS'({i_mby, 3'b000}) + IHBITS'(i_ccnt[3:1]);
    assign o_cuv = (i_ccnt >= 5'(CHROMA_PER_PLANE));

endmodule

// File: rtl/h264_mb_scheduler.sv
// Frame-level macroblock sequencer for the intra H.264 encoder.
// H264_PARALLEL_CHROMA_EN merges luma and chroma streaming into one STREAM state.
module h264_mb_scheduler
    import h264_sched_pkg::*;
#(
    parameter int unsigned IMGWIDTH  = 352,
    parameter int unsigned IMGHEIGHT = 288,
    parameter int unsigned IWBITS    = 9,
    parameter int unsigned IHBITS    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              newslice,
    output logic              newline,
    input  logic              intra4x4_readyi,
    output logic              intra4x4_strobei,
    output logic [IWBITS-1:0] x,
    output logic [IHBITS-1:0] y,
    input  logic              intra8x8cc_readyi,
    output logic              intra8x8cc_strobei,
    output logic [IWBITS-1:0] cx,
    output logic [IHBITS-1:0] cy,
    output logic              cuv,
    input  logic              xbuffer_done,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned MBW  = IMGWIDTH / 16;
    localparam int unsigned MBH  = IMGHEIGHT / 16;
    localparam int unsigned MBXW = clog2_min1(MBW);
    localparam int unsigned MBYW = clog2_min1(MBH);
    localparam logic [MBXW-1:0] MBX_LAST = MBXW'(MBW - 1);
    localparam logic [MBYW-1:0] MBY_LAST = MBYW'(MBH - 1);

    state_e          r_state, w_state_nxt;
    logic [MBXW-1:0] r_mbx, w_mbx_nxt;
    logic [MBYW-1:0] r_mby, w_mby_nxt;
    logic [6:0]      r_lcnt, w_lcnt_nxt, w_lcnt_inc;
    logic [5:0]      r_ccnt, w_ccnt_nxt, w_ccnt_inc;
    logic            r_sticky, w_sticky_nxt;
    logic            w_luma_full, w_chroma_full, w_last_mb;

`ifdef H264_PARALLEL_CHROMA_EN
    localparam state_e STREAM_ENTRY = STREAM;
    assign intra4x4_strobei   = (r_state == STREAM) & intra4x4_readyi
                              & (r_lcnt != 7'(LUMA_WORDS));
    assign intra8x8cc_strobei = (r_state == STREAM) & intra8x8cc_readyi
                              & (r_ccnt != 6'(CHROMA_WORDS));
`else
    localparam state_e STREAM_ENTRY = LUMA;
    assign intra4x4_strobei   = (r_state == LUMA) & intra4x4_readyi;
    assign intra8x8cc_strobei = (r_state == CHROMA) & intra8x8cc_readyi;
`endif

    assign w_lcnt_inc    = r_lcnt + 7'(intra4x4_strobei);
    assign w_ccnt_inc    = r_ccnt + 6'(intra8x8cc_strobei);
    assign w_luma_full   = (w_lcnt_inc == 7'(LUMA_WORDS));
    assign w_chroma_full = (w_ccnt_inc == 6'(CHROMA_WORDS));
    assign w_last_mb     = (r_mbx == MBX_LAST) && (r_mby == MBY_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mbx    <= '0;
            r_mby    <= '0;
            r_lcnt   <= '0;
            r_ccnt   <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mbx    <= w_mbx_nxt;
            r_mby    <= w_mby_nxt;
            r_lcnt   <= w_lcnt_nxt;
            r_ccnt   <= w_ccnt_nxt;
            r_sticky <= w_sticky_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mbx_nxt    = r_mbx;
        w_mby_nxt    = r_mby;
        w_lcnt_nxt   = w_lcnt_inc;
        w_ccnt_nxt   = w_ccnt_inc;
        w_sticky_nxt = r_sticky;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = SLICE;
            end
            SLICE, LINE: w_state_nxt = STREAM_ENTRY;
            LUMA: begin
                // An early done must survive until WAITX.
                if (xbuffer_done) w_sticky_nxt = 1'b1;
                if (w_luma_full) w_state_nxt = CHROMA;
            end
            CHROMA: begin
                if (xbuffer_done) w_sticky_nxt = 1'b1;
                if (w_chroma_full) w_state_nxt = WAITX;
            end
            STREAM: begin
                if (xbuffer_done) w_sticky_nxt = 1'b1;
                if (w_luma_full && w_chroma_full) w_state_nxt = WAITX;
            end
            WAITX: begin
                if (xbuffer_done || r_sticky) begin
                    w_sticky_nxt = 1'b0;
                    w_state_nxt  = w_last_mb ? DONE : NEXT;
                end
            end
            NEXT: begin
                w_lcnt_nxt = '0;
                w_ccnt_nxt = '0;
                if (r_mbx == MBX_LAST) begin
                    w_mbx_nxt   = '0;
                    w_mby_nxt   = r_mby + MBYW'(1);
                    w_state_nxt = LINE;
                end else begin
                    w_mbx_nxt   = r_mbx + MBXW'(1);
                    w_state_nxt = STREAM_ENTRY;
                end
            end
            DONE: begin
                w_mbx_nxt   = '0;
                w_mby_nxt   = '0;
                w_lcnt_nxt  = '0;
                w_ccnt_nxt  = '0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign newslice   = (r_state == SLICE);
    assign newline    = (r_state == LINE);
    assign frame_done = (r_state == DONE);
    assign busy       = (r_state != IDLE) && (r_state != DONE);

    h264_mb_addr_gen #(
        .MBXW   (MBXW),
        .MBYW   (MBYW),
        .IWBITS (IWBITS),
        .IHBITS (IHBITS)
    ) u_addr_gen (
        .i_mbx  (r_mbx),
        .i_mby  (r_mby),
        .i_lcnt (r_lcnt[5:0]),
        .i_ccnt (r_ccnt[4:0]),
        .o_x    (x),
        .o_y    (y),
        .o_cx   (cx),
        .o_cy   (cy),
        .o_cuv  (cuv)
    );

endmodule

// File: tb/tb_h264_mb_scheduler.sv
// Self-checking bench for h264_mb_scheduler on a 32x32 frame (2x2 macroblocks).
module tb_h264_mb_scheduler;

    localparam int MBW        = 2;
    localparam int MBH        = 2;
    localparam int NMB        = MBW * MBH;
    localparam int CYC_BUDGET = 4000;
`ifdef H264_PARALLEL_CHROMA_EN
    localparam int STREAM_LEN = 64;
    localparam int DUAL_EXP   = 32 * NMB;
    localparam int ABORT_CHR  = 95;
`else
    localparam int STREAM_LEN = 96;
    localparam int DUAL_EXP   = 0;
    localparam int ABORT_CHR  = 64;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       newslice, newline;
    logic       intra4x4_readyi = 1'b0;
    logic       intra4x4_strobei;
    logic [8:0] x, y, cx, cy;
    logic       intra8x8cc_readyi = 1'b0;
    logic       intra8x8cc_strobei;
    logic       cuv;
    logic       xbuffer_done = 1'b0;
    logic       busy, frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    h264_mb_scheduler #(
        .IMGWIDTH  (32),
        .IMGHEIGHT (32),
        .IWBITS    (9),
        .IHBITS    (9)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .newslice           (newslice),
        .newline            (newline),
        .intra4x4_readyi    (intra4x4_readyi),
        .intra4x4_strobei   (intra4x4_strobei),
        .x                  (x),
        .y                  (y),
        .intra8x8cc_readyi  (intra8x8cc_readyi),
        .intra8x8cc_strobei (intra8x8cc_strobei),
        .cx                 (cx),
        .cy                 (cy),
        .cuv                (cuv),
        .xbuffer_done       (xbuffer_done),
        .busy               (busy),
        .frame_done         (frame_done)
    );

    typedef struct {
        int x;
        int y;
        int uv;
    } addr_t;

    // Inputs: ready modes (0 always, 1 pattern 1,0,0,1, 2 random), done delay after stream end,
    // early-done and extra-done masks per macroblock, abort point; then expected event counts.
    typedef struct {
        int lmode;
        int cmode;
        int delay;
        int early_mask;
        int extra_mask;
        int abort_at;
        int exp_luma;
        int exp_chroma;
        int exp_slice;
        int exp_line;
        int exp_fdone;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit pick(input int mode, input int cyc);
        bit [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[cyc % 4];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_newslice"}, newslice, 0);
        chk({tag, "_newline"}, newline, 0);
        chk({tag, "_luma_stb"}, intra4x4_strobei, 0);
        chk({tag, "_chroma_stb"}, intra8x8cc_strobei, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_cx"}, cx, 0);
        chk({tag, "_cy"}, cy, 0);
        chk({tag, "_cuv"}, cuv, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic run_vec(input vec_t v);
        addr_t lq[$];
        addr_t cq[$];
        addr_t e;
        int luma_tot = 0, chroma_tot = 0, n_slice = 0, n_line = 0, n_fd = 0, dual = 0;
        int mb = 0, lc = 0, cc = 0, early_at = -1, late_at = -1, end_cyc = 0, first_cyc = 0;
        int eff = 0, rst_cyc = -1, fd_cyc = -1;
        bit finished = 1'b0;
        bit lr, cr;
        for (int my = 0; my < MBH; my++)
            for (int mx = 0; mx < MBW; mx++) begin
                for (int r = 0; r < 16; r++)
                    for (int w = 0; w < 4; w++) lq.push_back('{mx * 16 + w * 4, my * 16 + r, 0});
                for (int p = 0; p < 2; p++)
                    for (int r = 0; r < 8; r++)
                        for (int w = 0; w < 2; w++) cq.push_back('{mx * 8 + w * 4, my * 8 + r, p});
            end
        for (int cyc = 0; cyc < CYC_BUDGET && !finished; cyc++) begin
            lr = pick(v.lmode, cyc);
            cr = pick(v.cmode, cyc + 1);
            start             = (cyc == 0);
            intra4x4_readyi   = lr;
            intra8x8cc_readyi = cr;
            xbuffer_done      = (cyc == early_at) || (cyc == late_at);
            rst               = (cyc == rst_cyc);
            @(negedge clk);
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
                check_idle("abort");
                finished = 1'b1;
            end else begin
                if (newslice) begin
                    n_slice++;
                    chk("newslice_cyc", cyc, 1);
                    chk("busy_slice", busy, 1);
                end
                if (newline) begin
                    n_line++;
                    chk("newline_row_start", (mb > 0 && mb % MBW == 0 && lc == 0), 1);
                end
                if (frame_done) begin
                    n_fd++;
                    fd_cyc = cyc;
                    chk("fdone_mb", mb, NMB);
                    chk("fdone_busy", busy, 0);
                end
                if (intra4x4_strobei && intra8x8cc_strobei) dual++;
                if (intra4x4_strobei) begin
                    chk("luma_ready", lr, 1);
                    if (lq.size() == 0) chk("luma_extra", luma_tot, 64 * NMB);
                    else begin
                        e = lq.pop_front();
                        chk("luma_x", x, e.x);
                        chk("luma_y", y, e.y);
                    end
                    if (mb == 1 && lc == 5) begin
                        chk("mb1_w5_x", x, 20);
                        chk("mb1_w5_y", y, 1);
                    end
                    if (lc == 0) begin
                        if (mb > 0 && v.lmode == 0)
                            chk("mb_gap", cyc - end_cyc, eff + 2 + ((mb % MBW == 0) ? 1 : 0));
                        first_cyc = cyc;
                    end
                    lc++;
                    luma_tot++;
                    if (lc == 10 && v.early_mask[mb]) early_at = cyc + 1;
                    if (v.abort_at >= 0 && luma_tot == v.abort_at && rst_cyc < 0)
                        rst_cyc = cyc + 1;
                end else if (lc > 0 && lc < 64) begin
                    chk("luma_stall_ready", lr, 0);
                    chk("luma_hold_x", x, lq[0].x);
                    chk("luma_hold_y", y, lq[0].y);
                end
                if (intra8x8cc_strobei) begin
                    chk("chroma_ready", cr, 1);
                    if (cq.size() == 0) chk("chroma_extra", chroma_tot, 32 * NMB);
                    else begin
                        e = cq.pop_front();
                        chk("chroma_cx", cx, e.x);
                        chk("chroma_cy", cy, e.y);
                        chk("chroma_cuv", cuv, e.uv);
                    end
                    if (mb == 1 && cc == 17) begin
                        chk("mb1_c17_cx", cx, 12);
                        chk("mb1_c17_cy", cy, 0);
                        chk("mb1_c17_cuv", cuv, 1);
                    end
                    cc++;
                    chroma_tot++;
                end else if (cc > 0 && cc < 32) begin
                    chk("chroma_stall_ready", cr, 0);
                    chk("chroma_hold_cx", cx, cq[0].x);
                    chk("chroma_hold_cy", cy, cq[0].y);
                end
                if (lc == 64 && cc == 32) begin
                    end_cyc = cyc;
                    if (v.lmode == 0 && v.cmode == 0)
                        chk("stream_len", cyc - first_cyc + 1, STREAM_LEN);
                    if (v.early_mask[mb]) begin
                        eff     = 1;
                        late_at = v.extra_mask[mb] ? cyc + 1 : -1;
                    end else begin
                        eff     = v.delay;
                        late_at = cyc + v.delay;
                    end
                    mb++;
                    lc = 0;
                    cc = 0;
                end
                if (fd_cyc >= 0 && cyc == fd_cyc + 1) begin
                    chk("busy_after_done", busy, 0);
                    finished = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        start             = 1'b0;
        rst               = 1'b0;
        intra4x4_readyi   = 1'b0;
        intra8x8cc_readyi = 1'b0;
        xbuffer_done      = 1'b0;
        chk("finished_in_budget", finished, 1);
        chk("luma_count", luma_tot, v.exp_luma);
        chk("chroma_count", chroma_tot, v.exp_chroma);
        chk("newslice_count", n_slice, v.exp_slice);
        chk("newline_count", n_line, v.exp_line);
        chk("frame_done_count", n_fd, v.exp_fdone);
        if (v.abort_at < 0 && v.lmode == 0 && v.cmode == 0) chk("dual_strobes", dual, DUAL_EXP);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 0, 3, 0, 0, -1, 256, 128, 1, 1, 1};
        vecs[1] = '{1, 0, 2, 0, 0, -1, 256, 128, 1, 1, 1};
        vecs[2] = '{2, 2, 1, 0, 0, -1, 256, 128, 1, 1, 1};
        vecs[3] = '{0, 0, 4, 5, 5, -1, 256, 128, 1, 1, 1};
        vecs[4] = '{0, 0, 3, 0, 0, 158, 159, ABORT_CHR, 1, 1, 0};
        vecs[5] = '{0, 1, 2, 8, 0, -1, 256, 128, 1, 1, 1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            repeat (2) @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
